phase_generator: RTL and testbench
==================================

Name: phase_generator

Overview:
- Parametrised multi-phase timing generator for the core timing path; the next generation of the two-phase clock splitter.
- All logic runs in the single i_base_clock domain and produces NUM_PHASES non-overlapping, one-hot phase strobes.
- Phase length and dead time between phases are programmable at runtime.
- Supports free-run, stop at a phase boundary and single-step operation for debug.

Parameters:
- NUM_PHASES, 2, number of rotating phases, legal range 2..8
- CNT_WIDTH, 4, width of the phase-length and gap-length fields and of the internal counter
- IDX_WIDTH, 3, width of o_phase_index; must satisfy 2^IDX_WIDTH >= NUM_PHASES

Ports:
- i_base_clock  in  1  sole clock; all state changes on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_run  in  1  level; free-run enable
- i_step  in  1  pulse; execute exactly one phase (plus its gap) while idle
- i_phase_len  in  CNT_WIDTH  active cycles per phase; 0 is treated as 1
- i_gap_len  in  CNT_WIDTH  dead cycles after each phase; 0 means no gap
- o_phase  out  NUM_PHASES  one-hot active phase; all zero in gap or idle
- o_phase_start  out  NUM_PHASES  one-cycle pulse on the first active cycle of each phase
- o_cycle_done  out  1  pulse on the final active cycle of phase NUM_PHASES-1
- o_phase_index  out  IDX_WIDTH  index of the current or next phase
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - Reset is synchronous and takes priority over all other inputs.
  - After the reset edge: state IDLE, index 0, counter 0.
  - o_phase, o_phase_start, o_cycle_done, o_busy are 0; o_phase_index is 0.
  - A reset mid-phase or mid-gap zeroes all strobes in the following cycle; the partial phase is discarded.
- Outputs: all outputs are registered. An input sampled at edge k affects outputs visible after edge k.
- State IDLE:
  - If i_run=1 or i_step=1 at an edge, go to ACTIVE at the current index.
  - At ACTIVE entry: latch max(i_phase_len,1) and i_gap_len, and set the one-hot bit and the o_phase_start bit.
  - If i_run and i_step are both high, this is a run; the step is absorbed.
- State ACTIVE:
  - o_phase holds the one-hot bit for exactly the latched phase length.
  - On the final active cycle the index advances, wrapping from NUM_PHASES-1 to 0.
  - o_cycle_done asserts on that final cycle when the finishing index is NUM_PHASES-1.
  - If the latched gap is greater than 0, go to GAP.
  - If the latched gap is 0, apply the continue decision immediately. No idle bubble: the next phase bit is asserted on the very next cycle.
- State GAP:
  - o_phase is all zero for exactly the latched gap cycles.
  - The gap always completes even if i_run drops, which guarantees the dead time.
  - At the end of the gap, apply the continue decision.
- Continue decision:
  - If i_run=1, go to ACTIVE for the next index with newly latched lengths.
  - Otherwise go to IDLE; o_phase_index retains the next index, so a later restart resumes the rotation.
- Single step:
  - A step runs one phase plus its gap, then IDLE, unless i_run rises meanwhile.
  - i_step is ignored while o_busy=1; it is not queued.
- Length changes: changes to i_phase_len or i_gap_len mid-phase are ignored until the next phase entry.
- Invariants:
  - At most one bit of o_phase is ever set.
  - o_phase_start is a subset of o_phase.
- Legacy mode: NUM_PHASES=2, phase_len=1, gap=0 with run held gives two complementary half-rate strobes (10,01,10,...). This is the single-domain replacement for the old A/B clocks.

Test Plan:
1. Reset, then run held with NUM_PHASES=2, len=3, gap=1 -> o_phase sequence 01,01,01,00,10,10,10,00 repeating, period 8. o_phase_start fires on cycles 0 and 4; o_cycle_done fires on cycle 6 of each period.
2. NUM_PHASES=4, len=1, gap=0, run held -> o_phase 0001,0010,0100,1000 back to back with no zero cycles. o_cycle_done fires every 4th cycle; o_phase_index wraps 3 to 0.
3. Idle with len=2, gap=2; pulse i_step once -> exactly one phase 01,01 then 00,00, then IDLE with o_busy=0 and o_phase_index=1. A second step produces 10,10,00,00. A step pulsed while busy has no effect.
4. Run with len=4, gap=2; drop i_run during the second cycle of phase 0 -> phase 0 completes all 4 cycles, the 2 gap cycles complete, then IDLE with index 1. Re-raising i_run starts phase 1.
5. Change i_phase_len from 2 to 5 mid-phase -> the current phase keeps length 2 and the next phase lasts 5. Setting i_phase_len=0 gives 1-cycle phases.
6. Assert i_reset during phase 2 of a 4-phase run -> all outputs 0 on the next cycle and o_phase_index=0. Run restarts at phase 0.

Source files
------------

// File: rtl/phase_generator.sv
// phase_generator: rotating one-hot phase strobes with programmable phase length, dead time and step/run control
module phase_generator #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_WIDTH  = 4,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                  i_base_clock,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic [CNT_WIDTH-1:0]  i_phase_len,
  input  logic [CNT_WIDTH-1:0]  i_gap_len,
  output logic [NUM_PHASES-1:0] o_phase,
  output logic [NUM_PHASES-1:0] o_phase_start,
  output logic                  o_cycle_done,
  output logic [IDX_WIDTH-1:0]  o_phase_index,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PHASES - 1);
  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d, go_idx, next_idx;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, glen_q, glen_d, plen_in;
  logic [NUM_PHASES-1:0]  phase_q, phase_d, start_q, start_d;
  logic                   done_q, done_d, go;
  assign plen_in  = (i_phase_len == '0) ? CNT_WIDTH'(1) : i_phase_len;
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  // Sequence the phase/gap counter and compute the next registered strobes; cnt_q counts remaining cycles after the current one
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    glen_d  = glen_q;
    phase_d = '0;
    start_d = '0;
    done_d  = 1'b0;
    go      = 1'b0;
    go_idx  = idx_q;
    case (state_q)
      IDLE: go = i_run | i_step;
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          phase_d = phase_q;
          done_d  = (cnt_q == CNT_WIDTH'(1)) && (idx_q == LAST_IDX);
        end else begin
          idx_d  = next_idx;
          go_idx = next_idx;
          if (glen_q != '0) begin
            state_d = GAP;
            cnt_d   = glen_q - 1'b1;
          end else begin
            state_d = IDLE;
            go      = i_run;
          end
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          go      = i_run;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = ACTIVE;
      idx_d   = go_idx;
      glen_d  = i_gap_len;
      cnt_d   = plen_in - 1'b1;
      phase_d = NUM_PHASES'(1) << go_idx;
      start_d = NUM_PHASES'(1) << go_idx;
      done_d  = (plen_in == CNT_WIDTH'(1)) && (go_idx == LAST_IDX);
    end
  end
  // State and output registers; reset discards any partial phase or gap
  always_ff @(posedge i_base_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      glen_q  <= '0;
      phase_q <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      glen_q  <= glen_d;
      phase_q <= phase_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end
  assign o_phase       = phase_q;
  assign o_phase_start = start_q;
  assign o_cycle_done  = done_q;
  assign o_phase_index = idx_q;
  assign o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_phase_generator.sv
// tb_phase_generator: scoreboard bench driving 2-phase and 4-phase instances against a schedule-queue reference model
module tb_phase_generator;
  typedef struct packed {
    logic [7:0] ph;
    logic [7:0] st;
    logic       done;
    logic [2:0] idx;
    logic       busy;
  } frame_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] plen = 4'd1;
  logic [3:0] glen = 4'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = (g == 0) ? 2 : 4;
    logic [N-1:0] ph, st;
    logic         done, busy;
    logic [2:0]   idx;
    frame_t       sched[$];
    frame_t       expq[$];
    int           midx = 0;
    bit           mbusy = 1'b0;
    phase_generator #(.NUM_PHASES(N), .CNT_WIDTH(4), .IDX_WIDTH(3)) dut (
      .i_base_clock(clk), .i_reset(rst), .i_run(run), .i_step(step),
      .i_phase_len(plen), .i_gap_len(glen),
      .o_phase(ph), .o_phase_start(st), .o_cycle_done(done),
      .o_phase_index(idx), .o_busy(busy)
    );
    // Reference model: when idle, a start request appends the whole phase-plus-gap frame list; each edge consumes one frame
    always @(posedge clk) begin
      frame_t f;
      int     l, nx;
      f = '0;
      if (rst) begin
        sched.delete();
        midx = 0;
      end else begin
        if (sched.size() == 0 && (run || (step && !mbusy))) begin
          l  = (plen == 0) ? 1 : int'(plen);
          nx = (midx + 1) % N;
          for (int k = 0; k < l; k++) begin
            f      = '0;
            f.ph   = 8'(1 << midx);
            f.st   = (k == 0) ? f.ph : 8'd0;
            f.done = (k == l - 1) && (midx == N - 1);
            f.idx  = 3'(midx);
            f.busy = 1'b1;
            sched.push_back(f);
          end
          for (int k = 0; k < int'(glen); k++) begin
            f      = '0;
            f.idx  = 3'(nx);
            f.busy = 1'b1;
            sched.push_back(f);
          end
          midx = nx;
        end
        if (sched.size() != 0) f = sched.pop_front();
        else begin
          f     = '0;
          f.idx = 3'(midx);
        end
      end
      mbusy = f.busy;
      expq.push_back(f);
    end
    // Monitor: pops one expected frame per cycle and compares it plus the strobe invariants
    always @(negedge clk) begin
      frame_t e, a;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = '{ph: 8'(ph), st: 8'(st), done: done, idx: idx, busy: busy};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs N=%0d cyc=%0d got ph=%b st=%b done=%b idx=%0d busy=%b exp ph=%b st=%b done=%b idx=%0d busy=%b",
                   N, cycle, a.ph, a.st, a.done, a.idx, a.busy, e.ph, e.st, e.done, e.idx, e.busy);
        end
        n_checks++;
        if (!$onehot0(ph) || ((st & ~ph) != '0)) begin
          n_fail++;
          $display("FAIL invariant N=%0d cyc=%0d got ph=%b st=%b exp onehot0 ph with st within ph", N, cycle, ph, st);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(3);
    rst = 1'b0;
    plen = 4'd3; glen = 4'd1; run = 1'b1;
    cyc(24);
    run = 1'b0;
    cyc(12);
    plen = 4'd1; glen = 4'd0; run = 1'b1;
    cyc(16);
    run = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    plen = 4'd2; glen = 4'd2;
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(2);
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(8);
    step = 1'b1; run = 1'b1; cyc(1); step = 1'b0; run = 1'b0;
    cyc(8);
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(8);
    plen = 4'd4; glen = 4'd2; run = 1'b1;
    cyc(2);
    run = 1'b0;
    cyc(10);
    run = 1'b1;
    cyc(6);
    run = 1'b0;
    cyc(20);
    plen = 4'd2; glen = 4'd0; run = 1'b1;
    cyc(1);
    plen = 4'd5;
    cyc(12);
    plen = 4'd0;
    cyc(8);
    run = 1'b0;
    cyc(20);
    plen = 4'd2; glen = 4'd1; run = 1'b1;
    cyc(9);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    run = 1'b0;
    cyc(30);
    for (int i = 0; i < 600; i++) begin
      if (i % 7 == 0) begin
        plen = 4'($urandom_range(0, 4));
        glen = 4'($urandom_range(0, 3));
      end
      if (i % 13 == 0) run = ($urandom_range(0, 2) == 0);
      step = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0; run = 1'b0; step = 1'b0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
